// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit_if
// Description : Request/response and data-memory port bundle for the
//               load/store unit. The slave modport is the unit itself. The
//               master modport is its environment: the execute stage, the
//               response consumer and the memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface load_store_unit_if;
  // execute-stage request
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // response to consumer
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_error;
  // data memory port
  logic [31:0] mem_address;
  logic [31:0] mem_write_data;
  logic [3:0]  mem_byte_enable;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;

  modport master (
    output req_valid, req_write, req_funct3, req_addr, req_wdata,
    output resp_ready, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error,
    input  mem_address, mem_write_data, mem_byte_enable, mem_write_enable
  );

  modport slave (
    input  req_valid, req_write, req_funct3, req_addr, req_wdata,
    input  resp_ready, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error,
    output mem_address, mem_write_data, mem_byte_enable, mem_write_enable
  );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : Single-outstanding load/store controller for a word-addressed,
//               byte-enabled data memory. It checks the width code, the
//               alignment and the address range. It lane-shifts store data,
//               extracts and extends load data, and returns a registered
//               response that carries an error code.
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
  parameter int WORDS = 128
) (
  input  wire logic       clk,
  input  wire logic       nrst,
  load_store_unit_if.slave bus
);

  localparam logic [32:0] ADDR_LIMIT = 33'(WORDS) * 33'd4;

  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ALIGN = 2'b01;
  localparam logic [1:0] ERR_RANGE = 2'b10;
  localparam logic [1:0] ERR_FUNCT = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t      state, state_next;

  // captured request fields
  logic        write_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  // registered response
  logic [31:0] rdata_q;
  logic [1:0]  error_q;

  logic [1:0]  req_error;
  logic        illegal;
  logic        misaligned;
  logic        out_of_range;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] shifted;
  logic [31:0] load_data;

  // Classify the incoming request: an illegal width code wins over
  // misalignment, and misalignment wins over the range check.
  always_comb begin
    illegal      = (bus.req_funct3 == 3'b011) || (bus.req_funct3 == 3'b110) ||
                   (bus.req_funct3 == 3'b111) || (bus.req_funct3[2] && bus.req_write);
    misaligned   = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                   ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    out_of_range = ({1'b0, bus.req_addr} >= ADDR_LIMIT);
    req_error    = ERR_OK;
    if (illegal) begin
      req_error = ERR_FUNCT;
    end else if (misaligned) begin
      req_error = ERR_ALIGN;
    end else if (out_of_range) begin
      req_error = ERR_RANGE;
    end
  end

  // Compute the byte enables and the replicated store data. Both come only
  // from the captured fields, so no req_* path reaches the memory port.
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = wdata_q;
    case (funct3_q[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << addr_q[1:0];
        lane_wdata = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        lane_be    = 4'b0011 << addr_q[1:0];
        lane_wdata = {2{wdata_q[15:0]}};
      end
      default: begin
        lane_be    = 4'b1111;
        lane_wdata = wdata_q;
      end
    endcase
  end

  // Bring the addressed lane down to bit 0, then sign- or zero-extend it.
  always_comb begin
    shifted   = bus.mem_read_data >> {addr_q[1:0], 3'b000};
    load_data = shifted;
    case (funct3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'd0, shifted[7:0]};
      3'b101:  load_data = {16'd0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  // State register. Because reset is asynchronous, mem_write_enable drops
  // as soon as reset asserts during an access.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic, plus the handshake and memory-port outputs decoded
  // from the state.
  always_comb begin
    state_next           = state;
    bus.req_ready        = 1'b0;
    bus.resp_valid       = 1'b0;
    bus.mem_address      = 32'd0;
    bus.mem_write_data   = 32'd0;
    bus.mem_byte_enable  = 4'd0;
    bus.mem_write_enable = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          state_next = (req_error == ERR_OK) ? ACCESS : RESP;
        end
      end
      ACCESS: begin
        bus.mem_address      = {addr_q[31:2], 2'b00};
        bus.mem_write_data   = lane_wdata;
        bus.mem_byte_enable  = lane_be;
        bus.mem_write_enable = write_q;
        state_next           = RESP;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Capture the request on acceptance and latch load data at the end of
  // the access. The response fields stay frozen while waiting in RESP.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      write_q  <= 1'b0;
      funct3_q <= 3'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      error_q  <= ERR_OK;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            write_q  <= bus.req_write;
            funct3_q <= bus.req_funct3;
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata;
            rdata_q  <= 32'd0;
            error_q  <= req_error;
          end
        end
        ACCESS: begin
          if (!write_q) begin
            rdata_q <= load_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.resp_rdata = rdata_q;
  assign bus.resp_error = error_q;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_load_store_unit
// Description : Directed self-checking bench for load_store_unit. It models a
//               128-word byte-enabled memory and scoreboards responses in
//               issue order.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_load_store_unit;

  logic clk = 1'b0;
  logic nrst;
  int   total = 0;
  int   bad   = 0;
  int   we_count = 0;
  bit   mem_loaded;

  logic [31:0] mem [0:127];
  logic [33:0] sb [$];

  load_store_unit_if bus ();

  load_store_unit #(.WORDS(128)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Memory model: combinational read and byte-enabled write at the clock edge.
  // It is loaded once with a recognisable pattern.
  assign bus.mem_read_data = mem[bus.mem_address[8:2]];

  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 128; i++) mem[i] <= 32'hA000_0000 | 32'(i);
      mem_loaded <= 1'b1;
    end else if (bus.mem_write_enable) begin
      for (int i = 0; i < 4; i++)
        if (bus.mem_byte_enable[i])
          mem[bus.mem_address[8:2]][8*i +: 8] <= bus.mem_write_data[8*i +: 8];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Count write strobes and retire responses from the scoreboard at handshake.
  always @(negedge clk) begin
    if (bus.mem_write_enable) we_count++;
    if (nrst && bus.resp_valid && bus.resp_ready) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_resp", 32'd1, 32'd0);
      end else begin
        logic [33:0] e;
        e = sb.pop_front();
        chk("resp_rdata", bus.resp_rdata, e[33:2]);
        chk("resp_error", 32'(bus.resp_error), 32'(e[1:0]));
      end
    end
  end

  // One request from acceptance to response handshake, with cycle-exact checks.
  task automatic do_req(input string tag, input logic w, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] exp_rd, input logic [1:0] exp_err,
                        input logic [3:0] exp_be, input logic [31:0] exp_wd);
    int we_before;
    we_before = we_count;
    sb.push_back({exp_rd, exp_err});
    chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = d;
    @(posedge clk); #1;
    bus.req_valid  = 1'b0;
    bus.req_write  = ~w;
    bus.req_funct3 = 3'b111;
    bus.req_addr   = 32'hFFFF_FFFF;
    bus.req_wdata  = 32'h5A5A_5A5A;
    if (exp_err == 2'b00) begin
      chk({tag, "_mem_address"}, bus.mem_address, {a[31:2], 2'b00});
      chk({tag, "_byte_enable"}, 32'(bus.mem_byte_enable), 32'(exp_be));
      chk({tag, "_write_enable"}, 32'(bus.mem_write_enable), 32'(w));
      if (w) chk({tag, "_write_data"}, bus.mem_write_data, exp_wd);
      chk({tag, "_access_resp_valid"}, 32'(bus.resp_valid), 32'd0);
      chk({tag, "_access_req_ready"}, 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
    end
    chk({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd1);
    chk({tag, "_resp_req_ready"}, 32'(bus.req_ready), 32'd0);
    chk({tag, "_resp_mem_idle"},
        32'(bus.mem_write_enable) | 32'(bus.mem_byte_enable) | bus.mem_address, 32'd0);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk({tag, "_after_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    chk({tag, "_after_req_ready"}, 32'(bus.req_ready), 32'd1);
    chk({tag, "_we_cycles"}, 32'(we_count - we_before),
        32'((w && exp_err == 2'b00) ? 1 : 0));
  endtask

  initial begin
    nrst           = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = 32'd0;
    bus.req_wdata  = 32'd0;
    bus.resp_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk) nrst = 1'b1;
    @(posedge clk); #1;

    // reset state
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_error", 32'(bus.resp_error), 32'd0);
    chk("rst_mem_outputs", bus.mem_address | bus.mem_write_data |
        32'(bus.mem_byte_enable) | 32'(bus.mem_write_enable), 32'd0);

    // word store/load
    do_req("sw10", 1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, 32'h0, 2'b00, 4'b1111, 32'hDEAD_BEEF);
    do_req("lw10", 1'b0, 3'b010, 32'h10, 32'h0, 32'hDEAD_BEEF, 2'b00, 4'b1111, 32'h0);

    // byte store into a known word, then signed/unsigned/word reads
    do_req("sw10b", 1'b1, 3'b010, 32'h10, 32'h1122_3344, 32'h0, 2'b00, 4'b1111, 32'h1122_3344);
    do_req("sb13", 1'b1, 3'b000, 32'h13, 32'h0000_00A5, 32'h0, 2'b00, 4'b1000, 32'hA5A5_A5A5);
    do_req("lb13", 1'b0, 3'b000, 32'h13, 32'h0, 32'hFFFF_FFA5, 2'b00, 4'b1000, 32'h0);
    do_req("lbu13", 1'b0, 3'b100, 32'h13, 32'h0, 32'h0000_00A5, 2'b00, 4'b1000, 32'h0);
    do_req("lw10c", 1'b0, 3'b010, 32'h10, 32'h0, 32'hA522_3344, 2'b00, 4'b1111, 32'h0);

    // upper halfword
    do_req("sh22", 1'b1, 3'b001, 32'h22, 32'h0000_8001, 32'h0, 2'b00, 4'b1100, 32'h8001_8001);
    do_req("lh22", 1'b0, 3'b001, 32'h22, 32'h0, 32'hFFFF_8001, 2'b00, 4'b1100, 32'h0);
    do_req("lhu22", 1'b0, 3'b101, 32'h22, 32'h0, 32'h0000_8001, 2'b00, 4'b1100, 32'h0);
    chk("mem_word_20", mem[8], 32'h8001_0008);

    // last in-range word
    do_req("sw1fc", 1'b1, 3'b010, 32'h1FC, 32'h0BAD_F00D, 32'h0, 2'b00, 4'b1111, 32'h0BAD_F00D);
    chk("mem_word_1fc", mem[127], 32'h0BAD_F00D);

    // error responses
    do_req("lw06", 1'b0, 3'b010, 32'h06, 32'h0, 32'h0, 2'b01, 4'b0000, 32'h0);
    do_req("sh01", 1'b1, 3'b001, 32'h01, 32'hFFFF, 32'h0, 2'b01, 4'b0000, 32'h0);
    do_req("sw200", 1'b1, 3'b010, 32'h200, 32'h1234_5678, 32'h0, 2'b10, 4'b0000, 32'h0);
    do_req("f3_011", 1'b0, 3'b011, 32'h0, 32'h0, 32'h0, 2'b11, 4'b0000, 32'h0);
    do_req("sbu_store", 1'b1, 3'b100, 32'h4, 32'hFF, 32'h0, 2'b11, 4'b0000, 32'h0);
    do_req("sw_odd_oor", 1'b1, 3'b010, 32'h203, 32'h0, 32'h0, 2'b01, 4'b0000, 32'h0);
    chk("mem_word_0_kept", mem[0], 32'hA000_0000);
    chk("mem_word_4_kept", mem[1], 32'hA000_0001);

    // back-pressure: response held 5 cycles while the next request waits
    sb.push_back({32'hA522_3344, 2'b00});
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h10;
    @(posedge clk); #1;
    sb.push_back({32'h0000_00A5, 2'b00});
    bus.req_funct3 = 3'b100;
    bus.req_addr   = 32'h13;
    chk("hold_access_req_ready", 32'(bus.req_ready), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("hold_resp_rdata", bus.resp_rdata, 32'hA522_3344);
      chk("hold_req_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("hold_idle_req_ready", 32'(bus.req_ready), 32'd1);
    chk("hold_not_yet_accepted", 32'(bus.mem_byte_enable), 32'd0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("hold_second_be", 32'(bus.mem_byte_enable), 32'h8);
    chk("hold_second_addr", bus.mem_address, 32'h10);
    @(posedge clk); #1;
    chk("hold_second_resp_valid", 32'(bus.resp_valid), 32'd1);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;

    // reset in the middle of a store access
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_funct3 = 3'b010;
    bus.req_addr   = 32'h30;
    bus.req_wdata  = 32'h1234_5678;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rst_mid_we_before", 32'(bus.mem_write_enable), 32'd1);
    #2 nrst = 1'b0;
    #1;
    chk("rst_mid_we_dropped", 32'(bus.mem_write_enable), 32'd0);
    chk("rst_mid_addr_zero", bus.mem_address, 32'd0);
    @(posedge clk);
    @(negedge clk) nrst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_word_kept", mem[12], 32'hA000_000C);
    chk("rst_mid_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_mid_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Watchdog in case the sequence ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
